// File: rtl/pong_ball_ctrl.sv
// pong_ball_ctrl: once-per-frame game engine for ball, paddle, serve/miss and score.
// All state updates on the cycle after frame_tick; every output is a register.
module pong_ball_ctrl #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int BALL_SIZE    = 8,
    parameter int PADDLE_H     = 64,
    parameter int PADDLE_X     = 616,
    parameter int BALL_SPEED   = 2,
    parameter int PADDLE_SPEED = 4,
    parameter int SERVE_FRAMES = 60,
    parameter int MISS_FRAMES  = 30
) (
    input  logic       clk_25,
    input  logic       rst,
    input  logic [9:0] x_count,
    input  logic [9:0] y_count,
    input  logic       btn_up,
    input  logic       btn_dn,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [9:0] paddle_y,
    output logic       ball_visible,
    output logic       miss,
    output logic [3:0] score,
    output logic       frame_tick
);

    typedef enum logic [1:0] {
        S_SERVE = 2'd0,
        S_PLAY  = 2'd1,
        S_MISS  = 2'd2
    } state_t;

    localparam logic [9:0]  BALL_X0      = 10'((H_RES - BALL_SIZE) / 2);
    localparam logic [9:0]  BALL_Y0      = 10'((V_RES - BALL_SIZE) / 2);
    localparam logic [9:0]  PADDLE_Y0    = 10'((V_RES - PADDLE_H) / 2);
    localparam logic [9:0]  TICK_LINE    = 10'(V_RES);
    localparam logic [10:0] BALL_Y_MAX   = 11'(V_RES - BALL_SIZE);
    localparam logic [10:0] PADDLE_Y_MAX = 11'(V_RES - PADDLE_H);
    localparam logic [10:0] HIT_X        = 11'(PADDLE_X - BALL_SIZE);
    localparam logic [10:0] BSPD         = 11'(BALL_SPEED);
    localparam logic [10:0] PSPD         = 11'(PADDLE_SPEED);
    localparam logic [10:0] BSIZE        = 11'(BALL_SIZE);
    localparam logic [10:0] PHGT         = 11'(PADDLE_H);
    localparam logic [7:0]  SERVE_LAST   = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0]  MISS_LAST    = 8'(MISS_FRAMES - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [9:0] r_ball_x;
    logic [9:0] r_ball_y;
    logic [9:0] r_paddle_y;
    logic       r_dx_right;
    logic       r_dy_down;
    logic       r_serve_dy_down;
    logic       r_visible;
    logic       r_miss;
    logic [3:0] r_score;
    logic       r_frame_tick;
    logic       r_up_s1;
    logic       r_up_s2;
    logic       r_dn_s1;
    logic       r_dn_s2;

    logic [10:0] w_bx11;
    logic [10:0] w_by11;
    logic [10:0] w_py11;
    logic [10:0] w_nx;
    logic        w_overlap;
    logic [9:0]  w_py_next;
    logic [9:0]  w_by_next;
    logic        w_dy_next;
    logic [9:0]  w_bx_next;
    logic        w_dx_next;
    logic        w_hit;
    logic        w_missed;

    assign w_bx11    = {1'b0, r_ball_x};
    assign w_by11    = {1'b0, r_ball_y};
    assign w_py11    = {1'b0, r_paddle_y};
    assign w_nx      = w_bx11 + BSPD;
    assign w_overlap = (w_by11 + BSIZE > w_py11) && (w_by11 < w_py11 + PHGT);

    always_comb begin
        w_py_next = r_paddle_y;
        if (r_up_s2 && !r_dn_s2) begin
            if (w_py11 <= PSPD) begin
                w_py_next = 10'd0;
            end else begin
                w_py_next = r_paddle_y - PSPD[9:0];
            end
        end else if (r_dn_s2 && !r_up_s2) begin
            if (w_py11 + PSPD >= PADDLE_Y_MAX) begin
                w_py_next = PADDLE_Y_MAX[9:0];
            end else begin
                w_py_next = r_paddle_y + PSPD[9:0];
            end
        end
    end

    always_comb begin
        w_by_next = r_ball_y;
        w_dy_next = r_dy_down;
        if (r_dy_down) begin
            if (w_by11 + BSPD >= BALL_Y_MAX) begin
                w_by_next = BALL_Y_MAX[9:0];
                w_dy_next = 1'b0;
            end else begin
                w_by_next = r_ball_y + BSPD[9:0];
            end
        end else begin
            if (w_by11 <= BSPD) begin
                w_by_next = 10'd0;
                w_dy_next = 1'b1;
            end else begin
                w_by_next = r_ball_y - BSPD[9:0];
            end
        end
    end

    // Paddle overlap is judged on pre-update ball and paddle positions.
    always_comb begin
        w_bx_next = r_ball_x;
        w_dx_next = r_dx_right;
        w_hit     = 1'b0;
        w_missed  = 1'b0;
        if (!r_dx_right) begin
            if (w_bx11 <= BSPD) begin
                w_bx_next = 10'd0;
                w_dx_next = 1'b1;
            end else begin
                w_bx_next = r_ball_x - BSPD[9:0];
            end
        end else if (w_nx >= HIT_X) begin
            if (w_overlap) begin
                w_bx_next = HIT_X[9:0];
                w_dx_next = 1'b0;
                w_hit     = 1'b1;
            end else begin
                w_missed  = 1'b1;
            end
        end else begin
            w_bx_next = w_nx[9:0];
        end
    end

    always_ff @(posedge clk_25 or negedge rst) begin
        if (!rst) begin
            r_state         <= S_SERVE;
            r_cnt           <= 8'd0;
            r_ball_x        <= BALL_X0;
            r_ball_y        <= BALL_Y0;
            r_paddle_y      <= PADDLE_Y0;
            r_dx_right      <= 1'b1;
            r_dy_down       <= 1'b1;
            r_serve_dy_down <= 1'b1;
            r_visible       <= 1'b1;
            r_miss          <= 1'b0;
            r_score         <= 4'd0;
            r_frame_tick    <= 1'b0;
            r_up_s1         <= 1'b0;
            r_up_s2         <= 1'b0;
            r_dn_s1         <= 1'b0;
            r_dn_s2         <= 1'b0;
        end else begin
            r_up_s1      <= btn_up;
            r_up_s2      <= r_up_s1;
            r_dn_s1      <= btn_dn;
            r_dn_s2      <= r_dn_s1;
            r_frame_tick <= (x_count == 10'd0) && (y_count == TICK_LINE);

            if (r_frame_tick) begin
                r_paddle_y <= w_py_next;
                case (r_state)
                    S_SERVE: begin
                        r_ball_x  <= BALL_X0;
                        r_ball_y  <= BALL_Y0;
                        r_visible <= 1'b1;
                        if (r_cnt == SERVE_LAST) begin
                            r_state    <= S_PLAY;
                            r_cnt      <= 8'd0;
                            r_dx_right <= 1'b1;
                            r_dy_down  <= r_serve_dy_down;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    S_PLAY: begin
                        r_cnt     <= 8'd0;
                        r_ball_y  <= w_by_next;
                        r_dy_down <= w_dy_next;
                        if (w_missed) begin
                            r_state   <= S_MISS;
                            r_visible <= 1'b0;
                            r_miss    <= 1'b1;
                        end else begin
                            r_ball_x   <= w_bx_next;
                            r_dx_right <= w_dx_next;
                            if (w_hit && (r_score != 4'hF)) begin
                                r_score <= r_score + 4'd1;
                            end
                        end
                    end
                    S_MISS: begin
                        if (r_cnt == MISS_LAST) begin
                            r_state         <= S_SERVE;
                            r_cnt           <= 8'd0;
                            r_ball_x        <= BALL_X0;
                            r_ball_y        <= BALL_Y0;
                            r_visible       <= 1'b1;
                            r_miss          <= 1'b0;
                            r_score         <= 4'd0;
                            // Each new serve flips the vertical launch direction.
                            r_serve_dy_down <= ~r_serve_dy_down;
                            r_dy_down       <= ~r_serve_dy_down;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    default: begin
                        r_state <= S_SERVE;
                        r_cnt   <= 8'd0;
                    end
                endcase
            end
        end
    end

    assign ball_x       = r_ball_x;
    assign ball_y       = r_ball_y;
    assign paddle_y     = r_paddle_y;
    assign ball_visible = r_visible;
    assign miss         = r_miss;
    assign score        = r_score;
    assign frame_tick   = r_frame_tick;

endmodule

// File: doc/pong_ball_ctrl.md
Name: pong_ball_ctrl

Overview:
- Game-state engine sitting between the sync/counter generator and the pong pixel renderer in the VGA pipeline.
- Consumes the pixel counters and two paddle buttons.
- Once per frame, during vertical blanking, it updates the ball and paddle positions, bounce directions, serve/miss state and hit score.
- The renderer only compares sx/sy against these registered outputs.

Parameters:
- H_RES, 640: active pixels per line.
- V_RES, 480: active lines per frame.
- BALL_SIZE, 8: ball edge length in pixels.
- PADDLE_H, 64: paddle height in pixels.
- PADDLE_X, 616: paddle left-edge x coordinate.
- BALL_SPEED, 2: ball step per frame on each axis.
- PADDLE_SPEED, 4: paddle step per frame.
- SERVE_FRAMES, 60: frames the ball rests at centre before play.
- MISS_FRAMES, 30: frames the miss flag is held after a miss.

Ports:
- clk_25  in  1  25.2 MHz pixel clock.
- rst  in  1  asynchronous, active-low reset.
- x_count  in  10  current pixel column from the sync generator.
- y_count  in  10  current line from the sync generator.
- btn_up  in  1  paddle up button; asynchronous, active-high.
- btn_dn  in  1  paddle down button; asynchronous, active-high.
- ball_x  out  10  ball left edge.
- ball_y  out  10  ball top edge.
- paddle_y  out  10  paddle top edge.
- ball_visible  out  1  renderer draws the ball when high.
- miss  out  1  high throughout the MISS state.
- score  out  4  consecutive paddle hits, saturating at 15.
- frame_tick  out  1  registered one-cycle update strobe.

Behaviour:
- Clock and reset: one clock, clk_25. rst is asynchronous, active-low. All state is registered.
- Reset values:
  - state = SERVE, frame counter = 0.
  - ball_x = 316, ball_y = 236 (centre).
  - dx = right, dy = down.
  - paddle_y = 208, score = 0, miss = 0, ball_visible = 1, frame_tick = 0.
- Button sync: btn_up and btn_dn each pass through a 2-flop synchronizer. Flops reset to 0.
- frame_tick:
  - Registered; high for exactly one cycle, the cycle after x_count==0 && y_count==V_RES are sampled.
  - All game updates happen on the frame_tick edge, so outputs change once per frame, inside blanking.
- Paddle (every tick, in every state):
  - Synced up=1, dn=0: paddle_y -= PADDLE_SPEED, clamped at 0.
  - Synced dn=1, up=0: paddle_y += PADDLE_SPEED, clamped at V_RES-PADDLE_H (416).
  - Both or neither pressed: hold.
- State machine (transitions only on tick):
  - SERVE:
    - Ball held at centre, ball_visible = 1, counter increments.
    - When counter reaches SERVE_FRAMES-1: go to PLAY, clear counter, dx = right.
    - dy toggles relative to the previous serve; it is down on the first serve after reset.
  - PLAY:
    - Vertical: down and ball_y+BALL_SPEED >= V_RES-BALL_SIZE (472) → ball_y = 472, dy = up.
    - Vertical: up and ball_y <= BALL_SPEED → ball_y = 0, dy = down.
    - Vertical: otherwise step by BALL_SPEED.
    - Horizontal: left and ball_x <= BALL_SPEED → ball_x = 0, dx = right.
    - Horizontal, right: compute nx = ball_x+BALL_SPEED. If nx >= PADDLE_X-BALL_SIZE (608), test overlap using pre-update values: ball_y+BALL_SIZE > paddle_y AND ball_y < paddle_y+PADDLE_H.
    - Overlap true (hit): ball_x = 608, dx = left, score += 1 saturating at 15.
    - Overlap false (miss): go to MISS, ball_visible = 0, miss = 1, counter cleared.
    - Horizontal: otherwise step by BALL_SPEED.
    - Vertical and horizontal updates are independent and may both bounce on the same tick (corner).
  - MISS:
    - Ball frozen and invisible, miss = 1, counter increments.
    - At MISS_FRAMES-1: go to SERVE, ball recentred, ball_visible = 1, miss = 0, score = 0, counter cleared.
- Arithmetic: all position maths is 10-bit unsigned. Comparisons are computed at 11 bits so nothing wraps.
- Counter width: 8 bits. Counter is held at 0 in PLAY.
- Reset mid-frame or mid-play: immediate return to the reset values. The next tick resumes SERVE counting from 0.
- Counter discontinuity (y_count never equals V_RES): no tick, all state holds.

Test Plan:
- Reset: assert rst=0 mid-line → all outputs at reset values within the same cycle. Release rst, run one frame → exactly one frame_tick, ball still at (316,236).
- Serve: run 60 frames → SERVE ends on tick 60. At tick 61 ball reads (318,238).
- Bottom bounce: force play with ball_y=471, dy=down → next tick ball_y=472 and dy=up; following tick ball_y=470.
- Paddle clamp: hold dn for 60 frames → paddle_y reaches 416 and holds. Press both buttons → no change. Hold up from 2 → paddle_y=0.
- Hit: paddle_y=200, ball_y=220, ball_x=606 moving right → ball_x=608, dx=left, score=1. Repeat 16 hits → score stays 15.
- Miss: paddle_y=0, ball_y=300, ball_x=606 → MISS state, miss=1, ball_visible=0 for 30 ticks, then SERVE with score=0 and ball at (316,236) with dy=up.
